// File: rtl/fft_input_loader_pkg.sv
// Shared types and default sizing for the FFT input loader.
package fft_input_loader_pkg;

  localparam int unsigned DefDWidth    = 64;
  localparam int unsigned DefLog2Width = 6;
  localparam int unsigned SampleW      = 16;

  // Signed Q7.8 sample part.
  typedef logic signed [SampleW-1:0] sample_t;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2
  } state_e;

  // Width of the hold-off counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream in, frame buffer / start pulse out.
// master: the sample producer and FFT consumer side; slave: the loader.
interface fft_input_loader_if #(
  parameter int unsigned D_WIDTH = fft_input_loader_pkg::DefDWidth
);
  import fft_input_loader_pkg::*;

  logic    in_valid;
  logic    in_ready;
  sample_t in_re;
  sample_t in_im;
  logic    in_ifft;
  logic    flush;
  sample_t out_re [D_WIDTH];
  sample_t out_im [D_WIDTH];
  logic    start;
  logic    ifft;
  logic    busy;

  modport master (
    output in_valid, in_re, in_im, in_ifft, flush,
    input  in_ready, out_re, out_im, start, ifft, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, in_ifft, flush,
    output in_ready, out_re, out_im, start, ifft, busy
  );

endinterface

// File: rtl/fft_index_reverse.sv
// Bit-reverses a sample index so frames land in the FFT's bit-reversed order.
module fft_index_reverse
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned LOG_2_WIDTH = DefLog2Width
) (
  input  logic [LOG_2_WIDTH-1:0] idx,
  output logic [LOG_2_WIDTH-1:0] idx_rev
);

  // Mirror the index bits.
  always_comb begin
    idx_rev = '0;
    for (int i = 0; i < LOG_2_WIDTH; i++) begin
      idx_rev[i] = idx[LOG_2_WIDTH-1-i];
    end
  end

endmodule

// File: rtl/fft_input_loader.sv
// Collects D_WIDTH complex samples into a frame buffer, pulses start to the
// FFT, then holds the buffer stable for FFT_CYCLES cycles before refilling.
// All state changes on the falling clock edge.
// Optional macro FFT_IN_BITREV_EN: store sample n at slot bitreverse(n).
module fft_input_loader
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned D_WIDTH     = DefDWidth,
  parameter int unsigned LOG_2_WIDTH = DefLog2Width,
  parameter int unsigned FFT_CYCLES  = 200
) (
  input logic               clk,
  input logic               rst,
  fft_input_loader_if.slave bus
);

  localparam int unsigned            CntW    = cnt_width(FFT_CYCLES);
  localparam logic [CntW-1:0]        CntLoad = CntW'(FFT_CYCLES - 1);
  localparam logic [LOG_2_WIDTH-1:0] LastIdx = LOG_2_WIDTH'(D_WIDTH - 1);

  state_e                 state_q, state_d;
  logic [LOG_2_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [LOG_2_WIDTH-1:0] wr_slot;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   ifft_q, ifft_d;
  sample_t                re_q [D_WIDTH];
  sample_t                im_q [D_WIDTH];
  logic                   xfer;

  // A flush in the same cycle as a valid sample discards the sample.
  assign xfer = (state_q == StFill) & bus.in_valid & ~bus.flush;

`ifdef FFT_IN_BITREV_EN
  fft_index_reverse #(
    .LOG_2_WIDTH(LOG_2_WIDTH)
  ) u_index_reverse (
    .idx    (wr_idx_q),
    .idx_rev(wr_slot)
  );
`else
  assign wr_slot = wr_idx_q;
`endif

  // Next-state logic: fill, one-cycle start, fixed-length hold-off.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    ifft_d   = ifft_q;
    unique case (state_q)
      StFill: begin
        if (bus.flush) begin
          wr_idx_d = '0;
        end else if (bus.in_valid) begin
          if (wr_idx_q == '0) begin
            ifft_d = bus.in_ifft;
          end
          if (wr_idx_q == LastIdx) begin
            wr_idx_d = '0;
            state_d  = StStart;
          end else begin
            wr_idx_d = wr_idx_q + LOG_2_WIDTH'(1);
          end
        end
      end
      StStart: begin
        state_d = StWait;
        cnt_d   = CntLoad;
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StFill;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Control state register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StFill;
      wr_idx_q <= '0;
      cnt_q    <= '0;
      ifft_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
      ifft_q   <= ifft_d;
    end
  end

  // Frame buffer; written only by accepted samples, so it is frozen outside FILL.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (xfer) begin
      re_q[wr_slot] <= bus.in_re;
      im_q[wr_slot] <= bus.in_im;
    end
  end

  // Outputs decoded straight from state so reset takes effect immediately.
  always_comb begin
    bus.in_ready = (state_q == StFill);
    bus.start    = (state_q == StStart);
    bus.busy     = (state_q != StFill);
    bus.ifft     = ifft_q;
    for (int i = 0; i < D_WIDTH; i++) begin
      bus.out_re[i] = re_q[i];
      bus.out_im[i] = im_q[i];
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized and directed bench for fft_input_loader against a frame-level model.
// Honours FFT_IN_BITREV_EN the same way as the design.
module tb_fft_input_loader;
  import fft_input_loader_pkg::*;

  localparam int N    = 64;
  localparam int LOGN = 6;
  localparam int CYC  = 200;

  logic clk = 1'b1;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fft_input_loader_if #(.D_WIDTH(N)) bus ();

  fft_input_loader #(
    .D_WIDTH    (N),
    .LOG_2_WIDTH(LOGN),
    .FFT_CYCLES (CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int start_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference model: buffer contents, samples collected so far, cycles left
  // during which the block refuses input (first of them is the start pulse).
  sample_t m_re [N];
  sample_t m_im [N];
  logic    m_ifft;
  int      m_count;
  int      m_hold;

  function automatic int rev(input int n);
    int r = 0;
    for (int b = 0; b < LOGN; b++) begin
      if (((n >> b) & 1) == 1) r = r + (1 << (LOGN - 1 - b));
    end
    return r;
  endfunction

  function automatic int slot(input int n);
`ifdef FFT_IN_BITREV_EN
    return rev(n);
`else
    return n;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_re[i] = '0;
      m_im[i] = '0;
    end
    m_ifft  = 1'b0;
    m_count = 0;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic v, input sample_t re, input sample_t im,
                            input logic fi, input logic fl);
    if (m_hold > 0) begin
      m_hold--;
    end else if (fl) begin
      m_count = 0;
    end else if (v) begin
      m_re[slot(m_count)] = re;
      m_im[slot(m_count)] = im;
      if (m_count == 0) m_ifft = fi;
      m_count++;
      if (m_count == N) begin
        m_count = 0;
        m_hold  = CYC + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"}, bus.in_ready, m_hold == 0);
    check({tag, ".busy"}, bus.busy, m_hold > 0);
    check({tag, ".start"}, bus.start, m_hold == CYC + 1);
    check({tag, ".ifft"}, bus.ifft, m_ifft);
    for (int i = 0; i < N; i++) begin
      if (bus.out_re[i] !== m_re[i]) check($sformatf("%s.out_re[%0d]", tag, i), bus.out_re[i], m_re[i]);
      else check("out_re", bus.out_re[i], m_re[i]);
      if (bus.out_im[i] !== m_im[i]) check($sformatf("%s.out_im[%0d]", tag, i), bus.out_im[i], m_im[i]);
      else check("out_im", bus.out_im[i], m_im[i]);
    end
  endtask

  // One clock: drive inputs, let the falling edge act, compare 1 unit later.
  task automatic cycle(input string tag, input logic v, input sample_t re, input sample_t im,
                       input logic fi, input logic fl);
    bus.in_valid = v;
    bus.in_re    = re;
    bus.in_im    = im;
    bus.in_ifft  = fi;
    bus.flush    = fl;
    @(negedge clk);
    model_step(v, re, im, fi, fl);
    #1;
    if (bus.start === 1'b1) start_seen++;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag, input logic v);
    bus.in_valid = v;
    bus.in_re    = 16'sd77;
    bus.in_im    = 16'sd77;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int all7;
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;
    bus.in_ifft  = 1'b0;
    bus.flush    = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Ramp frame: in_re = n, in_im = -n.
    for (int n = 0; n < N; n++) begin
      cycle("ramp", 1'b1, 16'(n), 16'(-n), 1'b0, 1'b0);
    end
    check("ramp.start_after_63", bus.start, 1);
`ifdef FFT_IN_BITREV_EN
    check("ramp.out_re1", bus.out_re[1], 32);
    check("ramp.out_re2", bus.out_re[2], 16);
`else
    check("ramp.out_re1", bus.out_re[1], 1);
    check("ramp.out_re2", bus.out_re[2], 2);
`endif
    check("ramp.out_re63", bus.out_re[63], 63);

    // Hold in_valid high through START + WAIT.
    for (int k = 0; k < CYC; k++) begin
      cycle("hold", 1'b1, 16'(300 + k), 16'(k), 1'b0, 1'b0);
    end
    check("hold.busy_last_wait", bus.busy, 1);
    cycle("hold", 1'b1, 16'sd500, 16'sd501, 1'b0, 1'b0);
    check("hold.ready_after_wait", bus.in_ready, 1);
    cycle("hold", 1'b1, 16'sd555, 16'sd556, 1'b0, 1'b0);
    check("hold.slot0", bus.out_re[0], 555);

    // Partial frame (10 samples total), flush with a colliding sample, then 64 sevens.
    for (int k = 0; k < 9; k++) cycle("flush", 1'b1, 16'(k + 40), 16'(k), 1'b0, 1'b0);
    cycle("flush", 1'b1, 16'sd999, 16'sd999, 1'b0, 1'b1);
    start_seen = 0;
    for (int k = 0; k < N; k++) cycle("sevens", 1'b1, 16'sd7, 16'sd7, 1'b0, 1'b0);
    idle("sevens", CYC + 1);
    check("sevens.start_pulses", start_seen, 1);
    all7 = 0;
    for (int i = 0; i < N; i++) if (bus.out_re[i] === 16'sd7) all7++;
    check("sevens.all_out_re", all7, N);

    // ifft latched from sample 0 only.
    for (int k = 0; k < N; k++) cycle("ifft1", 1'b1, 16'(k), 16'(k), k == 0, 1'b0);
    check("ifft1.latched", bus.ifft, 1);
    idle("ifft1", CYC + 1);
    cycle("ifft0", 1'b1, 16'sd1, 16'sd1, 1'b0, 1'b0);
    check("ifft0.after_idx0", bus.ifft, 0);
    for (int k = 1; k < N; k++) cycle("ifft0", 1'b1, 16'(k), 16'(k), 1'b1, 1'b0);
    check("ifft0.frame", bus.ifft, 0);
    idle("ifft0", CYC + 1);

    // Reset during sample 40, then during WAIT.
    for (int k = 0; k < 40; k++) cycle("rst40", 1'b1, 16'(k + 1), 16'(k + 2), 1'b0, 1'b0);
    start_seen = 0;
    do_reset("rst40", 1'b1);
    idle("rst40", 70);
    check("rst40.no_start", start_seen, 0);
    for (int k = 0; k < N; k++) cycle("rstw", 1'b1, 16'(k + 3), 16'(k + 4), 1'b0, 1'b0);
    idle("rstw", 50);
    start_seen = 0;
    do_reset("rstw", 1'b0);
    check("rstw.ready", bus.in_ready, 1);
    idle("rstw", CYC + 20);
    check("rstw.no_start", start_seen, 0);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      cycle("rand", $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 Parameter D_WIDTH, default 64, SHALL set the number of complex points per frame.
REQ-002 Parameter LOG_2_WIDTH, default 6, SHALL be log2(D_WIDTH) and set the sample-index width.
REQ-003 Parameter FFT_CYCLES, default 200, SHALL set the hold-off cycles after start before the next frame is accepted.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its falling edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 in_valid  input  1  SHALL mark that in_re/in_im carry a sample.
REQ-007 in_ready  output  1  SHALL mark that the block accepts a sample this cycle.
REQ-008 in_re, in_im  input  16 each  SHALL be signed Q7.8 sample parts.
REQ-009 in_ifft  input  1  SHALL select inverse transform; sampled with sample index 0.
REQ-010 flush  input  1  SHALL abort a partially filled frame.
REQ-011 out_re, out_im  output  16 x D_WIDTH arrays  SHALL present the frame buffer to the FFT.
REQ-012 start  output  1  SHALL be a one-cycle pulse telling the FFT to load out_re/out_im.
REQ-013 ifft  output  1  SHALL be the latched in_ifft of the current frame.
REQ-014 busy  output  1  SHALL be high in START and WAIT states.

Function
REQ-015 States: FILL, START, WAIT; the block SHALL enter FILL out of reset.
REQ-016 FILL: in_ready=1; a transfer SHALL occur only on a falling edge with in_valid & in_ready.
REQ-017 Each transfer SHALL write the sample to buffer slot wr_idx and increment wr_idx modulo D_WIDTH.
REQ-018 The transfer at wr_idx=D_WIDTH-1 SHALL move the state to START, wr_idx wrapping to 0.
REQ-019 START SHALL last exactly one cycle with start=1, in_ready=0, then go to WAIT.
REQ-020 WAIT SHALL load a counter with FFT_CYCLES-1, decrement each cycle, and return to FILL after exactly FFT_CYCLES cycles.
REQ-021 out_re/out_im and ifft SHALL stay stable from START through the end of WAIT.
REQ-022 flush in FILL SHALL reset wr_idx to 0 without clearing buffer contents; flush and a transfer in the same cycle SHALL discard the sample.
REQ-023 flush in START or WAIT SHALL be ignored.
REQ-024 in_ready SHALL be 0 in START and WAIT; in_valid there SHALL be ignored.
REQ-025 ifft SHALL update only on the index-0 transfer.

Reset
REQ-026 rst low SHALL immediately force state FILL, wr_idx 0, counter 0, start 0, ifft 0, busy 0, in_ready 1, and all buffer slots 16'h0000.
REQ-027 Reset mid-frame or mid-WAIT SHALL discard the frame with no start pulse.

Configuration
REQ-028 Macro FFT_IN_BITREV_EN defined: sample n SHALL be stored in slot bitreverse(n, LOG_2_WIDTH), so out_re/out_im are already in bit-reversed order.
REQ-029 Macro undefined: sample n SHALL be stored in slot n (natural order).

Structure
REQ-030 A shared package SHALL hold the state enum, the 16-bit sample typedef and the default D_WIDTH/LOG_2_WIDTH constants.
REQ-031 Bit-reversal SHALL be a sub-module fft_index_reverse, parameterised by LOG_2_WIDTH; it is instantiated only with FFT_IN_BITREV_EN.

Verification
REQ-032 Reset, then 64 back-to-back transfers with in_re=n, in_im=-n -> start high exactly on the cycle after transfer 63, out_re[n]=n (macro off).
REQ-033 Same stimulus, macro on -> out_re[1]=32, out_re[2]=16, out_re[63]=63.
REQ-034 After start, hold in_valid=1 -> in_ready=0 and busy=1 for 201 cycles (START + 200 WAIT), then in_ready=1 and sample accepted into slot 0.
REQ-035 Send 10 samples, assert flush, send 64 samples with value 7 -> one start pulse; all out_re=7.
REQ-036 in_ifft=1 on sample 0, 0 afterward -> ifft=1 for the whole frame; next frame with in_ifft=0 -> ifft=0 after its index-0 transfer.
REQ-037 Assert rst during sample 40 and again during WAIT -> no start pulse, buffers 0, in_ready=1 immediately.
